// File: rtl/ari_result_queue_if.sv
// Result type shared by the arithmetic unit and the writeback path, plus the
// bundle between the ALU/writeback side and ari_result_queue.
package ari_pkg;
  parameter int NUM_OF_ARI_ISSUE = 2;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } vuop_result_t;
endpackage

// Handshake: a wb_out slot transfers on a rising edge when its valid field is 1
// and wb_ready_in is 1; wb_out never depends on wb_ready_in in the same cycle.
// op_in has no ready: lanes are captured whenever their valid field is 1, and
// stall_out is the only back-pressure toward the arithmetic issue stage.
interface ari_result_queue_if
  import ari_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_IN  = NUM_OF_ARI_ISSUE,
  parameter int NUM_OUT = 2
);
  vuop_result_t               op_in [NUM_IN];
  logic                       flush_in;
  vuop_result_t               wb_out [NUM_OUT];
  logic                       wb_ready_in;
  logic                       stall_out;
  logic [$clog2(DEPTH):0]     count_out;
  logic                       overflow_err;

  modport master (
    output op_in, flush_in, wb_ready_in,
    input  wb_out, stall_out, count_out, overflow_err
  );

  modport slave (
    input  op_in, flush_in, wb_ready_in,
    output wb_out, stall_out, count_out, overflow_err
  );
endinterface

// File: rtl/ari_result_queue.sv
// In-order result buffer between the arithmetic unit and register writeback:
// compacts up to NUM_IN results per cycle, drains up to NUM_OUT per cycle.
module ari_result_queue
  import ari_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_IN  = NUM_OF_ARI_ISSUE,
  parameter int NUM_OUT = 2
) (
  input logic               clock,
  input logic               reset,
  ari_result_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] NUM_OUT_C  = CW'(NUM_OUT);
  localparam logic [CW-1:0] STALL_TH_C = CW'(DEPTH - 2 * NUM_IN);

  vuop_result_t    mem [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            stall_q;
  logic            overflow_q;

  logic [CW-1:0]   pops, pushes, free, count_next;
  logic            drop;
  logic [NUM_IN-1:0] wr_en;
  logic [AW-1:0]   wr_addr [NUM_IN];

  // Space freed by this cycle's pop is usable by this cycle's push.
  always_comb begin
    pops   = '0;
    pushes = '0;
    drop   = 1'b0;
    wr_en  = '0;
    for (int i = 0; i < NUM_IN; i++) wr_addr[i] = '0;

    if (bus.wb_ready_in) pops = (count > NUM_OUT_C) ? NUM_OUT_C : count;
    free = DEPTH_C - count + pops;

    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.op_in[i].valid) begin
        if (pushes < free) begin
          wr_en[i]   = 1'b1;
          wr_addr[i] = tail + AW'(pushes);
          pushes     = pushes + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    count_next = count - pops + pushes;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.flush_in) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      stall_q <= 1'b0;
    end else begin
      head    <= head + AW'(pops);
      tail    <= tail + AW'(pushes);
      count   <= count_next;
      stall_q <= (count_next > STALL_TH_C);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Payload storage needs no reset: stale entries are masked by count.
  always_ff @(posedge clock) begin
    if (!bus.flush_in) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (wr_en[i]) mem[wr_addr[i]] <= bus.op_in[i];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      bus.wb_out[k] = mem[head + AW'(k)];
      if (CW'(k) >= count) bus.wb_out[k].valid = 1'b0;
    end
  end

  assign bus.stall_out    = stall_q;
  assign bus.count_out    = count;
  assign bus.overflow_err = overflow_q;
endmodule

// File: doc/ari_result_queue.md
# ari_result_queue

Result buffer directly downstream of the arithmetic unit: it captures the up-to-`NUM_IN` registered ALU results produced each cycle and drains them in order to the register-file writeback ports under a ready handshake. The arithmetic unit cannot stall mid-flight, so this block absorbs those results and issues a registered `stall_out` credit signal back to the arithmetic issue stage. Flush discards all buffered results together with the results arriving in the same cycle.

## Interface
- `DEPTH`, 8: number of result entries; a power of two, ≥ 2·`NUM_IN`.
- `NUM_IN`, `NUM_OF_ARI_ISSUE`: result lanes from the arithmetic unit.
- `NUM_OUT`, 2: writeback slots presented per cycle.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; the block is held in reset while `reset` is 0.
- `op_in[NUM_IN]` in `vuop_result_t`: registered ALU results; a lane is valid when its `valid` field is 1 (an all-zero value is a bubble).
- `flush_in` in 1: pipeline flush, the same signal the arithmetic unit sees.
- `wb_out[NUM_OUT]` out `vuop_result_t`: oldest entries, in order; `wb_out[k].valid` is 1 iff `count > k`.
- `wb_ready_in` in 1: the consumer accepts every valid `wb_out` slot this cycle.
- `stall_out` out 1: registered; tells arithmetic issue to stop issuing.
- `count_out` out `$clog2(DEPTH)+1`: current occupancy.
- `overflow_err` out 1: sticky error flag; cleared only by reset.

## Operation
- Storage is a circular buffer with `head` and `tail` pointers of width `$clog2(DEPTH)`, wrapping modulo `DEPTH`, plus a `count` register.
- Push: the valid lanes of `op_in` are compacted in ascending lane order and written at `tail`, `tail+1`, and so on. Invalid lanes consume no entry.
- Pop: when `wb_ready_in` is 1, `pops = min(count, NUM_OUT)`. `head` advances by `pops`, and the corresponding `wb_out` slots are retired.
- `wb_out[k]` = entry at `head+k` (mod `DEPTH`), driven combinationally from registered storage. Its `valid` field is forced to 0 when `k >= count`.
- Next `count` = `count - pops + pushes`.
- Capacity check uses space after the pop: `free = DEPTH - count + pops`.
  - If `pushes > free`, the first `free` valid lanes are written, the rest are dropped, and `overflow_err` is set.
  - A correctly operating design never reaches this case.
- `stall_out` next = (`count_next` > `DEPTH - 2·NUM_IN`). This covers the one cycle already in flight in the arithmetic unit plus the one-cycle stall latency.
- Flush has priority over push and pop:
  - `head`, `tail` and `count` go to 0, and all `op_in` lanes that cycle are ignored.
  - `stall_out` goes to 0 next cycle; `overflow_err` is unchanged.
  - Storage contents need not be cleared; they are masked by `count`.
- Reset (`reset` = 0), asynchronous:
  - `head`, `tail` and `count` = 0; `stall_out` = 0; `overflow_err` = 0.
  - All `wb_out` valid fields are 0; `count_out` = 0.
  - Reset asserted mid-drain drops all entries immediately, with no partial pop.
- There is no fall-through: a result pushed in cycle t is first visible on `wb_out` in cycle t+1.

## Timing
- Latency from `op_in` to `wb_out` is 1 cycle when the queue is empty.
- Throughput is up to `NUM_IN` pushes and `NUM_OUT` pops per cycle, both in the same cycle.
- `wb_out` and `count_out` change only after a clock edge or on asynchronous reset. They are independent of `wb_ready_in` within the cycle, so there is no combinational ready-to-valid path.
- `stall_out` is a flop, so it reflects occupancy one cycle after the push or pop that caused it.
- Pointer wrap: from `tail` = `DEPTH-1`, a 2-lane push writes `DEPTH-1` and 0. `wb_out` must read across the wrap identically.
- Empty: `wb_ready_in` = 1 with `count` = 0 is a no-op.
- Full: a push with `count` = `DEPTH` is accepted only if a pop in the same cycle frees the space.

## Test plan
- Reset/idle: hold `reset`=0 for 3 cycles, then release with bubbles on `op_in` → `count_out`=0, `stall_out`=0, all `wb_out.valid`=0, `overflow_err`=0.
- Ordering and compaction (DEPTH=8, NUM_IN=2, NUM_OUT=2):
  - Cycle 0: lanes {A, bubble}; cycle 1: {B, C}; `wb_ready_in`=0.
  - Expected: `count_out`=3, `wb_out`={A, B}.
  - Then `wb_ready_in`=1 for 1 cycle → `wb_out`={C, invalid}, `count_out`=1.
- Backpressure/stall:
  - Push 2 per cycle with `wb_ready_in`=0.
  - After 3 pushes (`count`=6 > 4), `stall_out`=1 in the following cycle.
  - The 4th push reaches `count`=8 with no overflow.
  - A 5th push sets `overflow_err`=1 and `count` stays 8.
- Simultaneous push/pop at full: `count`=8, push 2 with `wb_ready_in`=1 → `count`=8, oldest two retired, new two at tail, `overflow_err` stays 0.
- Wrap-around: run 20 cycles of 2-in/2-out streaming with sequence numbers 0..39 → `wb_out` emits 0..39 strictly in order across pointer wraps, one cycle behind input.
- Flush and reset mid-operation:
  - With `count`=5, assert `flush_in` alongside 2 valid lanes → next cycle `count_out`=0, `wb_out` all invalid, `stall_out`=0.
  - Separately, drop `reset` between edges with `count`=4 → outputs clear immediately without waiting for an edge.
